inst_cache: RTL and testbench

Direct-mapped, one-instruction-per-line instruction cache between the memory arbiter and the instruction fetcher. It accepts the fetcher's PC and returns a 32-bit instruction with a one-cycle ready pulse. A hit is served in one cycle. A miss fills the line from the byte-wide memory arbiter, four bytes, little-endian. A branch flush (`_clear`) aborts any outstanding fill.

---
 rtl/inst_cache.sv | 167 ++++++++++++++++
 tb/tb_inst_cache.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache, one 32-bit word per line.
// Hits are answered in one cycle from the tag/data arrays. Misses fetch four
// bytes (little-endian) from the byte-wide memory arbiter. A branch flush
// aborts an outstanding fill without writing the line.
module inst_cache #(
  parameter int unsigned LINES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _fetch_en,
  input  logic [31:0] _pc,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_out,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic        _mem_data_valid,
  input  logic [7:0]  _mem_data
);

  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [29:0] fill_addr_q, fill_addr_d;
  logic [23:0] fill_buf_q, fill_buf_d;
  logic        ready_q, ready_d;
  logic [31:0] inst_q, inst_d;
  logic        req_q, req_d;
  logic [31:0] maddr_q, maddr_d;

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_mem_q  [LINES];
  logic [31:0]      data_mem_q [LINES];

  logic [IDX-1:0]  pc_idx;
  logic [TAGW-1:0] pc_tag;
  logic            hit;
  logic            line_we;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic [31:0]     fill_word;
  logic            unused_pc_lo;

  assign unused_pc_lo = ^_pc[1:0];
  assign pc_idx       = _pc[IDX+1:2];
  assign pc_tag       = _pc[31:IDX+2];
  assign hit          = valid_q[pc_idx] && (tag_mem_q[pc_idx] == pc_tag);
  assign fill_idx     = fill_addr_q[IDX-1:0];
  assign fill_tag     = fill_addr_q[29:IDX];
  // The 4th byte is taken straight from the bus so the line write and the
  // response word are available in the same cycle the byte arrives.
  assign fill_word    = {_mem_data, fill_buf_q};

  assign _inst_ready_out = ready_q;
  assign _inst_out       = inst_q;
  assign _mem_req        = req_q;
  assign _mem_addr       = maddr_q;

  // Next-state and output logic for lookup / fill / response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_addr_d = fill_addr_q;
    fill_buf_d  = fill_buf_q;
    ready_d     = 1'b0;
    inst_d      = inst_q;
    req_d       = req_q;
    maddr_d     = maddr_q;
    line_we     = 1'b0;

    if (_clear) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (_fetch_en) begin
            if (hit) begin
              inst_d  = data_mem_q[pc_idx];
              ready_d = 1'b1;
            end else begin
              fill_addr_d = _pc[31:2];
              maddr_d     = {_pc[31:2], 2'b00};
              req_d       = 1'b1;
              cnt_d       = '0;
              state_d     = S_FILL;
            end
          end
        end
        S_FILL: begin
          if (_mem_data_valid) begin
            cnt_d = cnt_q + 2'd1;
            unique case (cnt_q)
              2'd0: fill_buf_d[7:0]   = _mem_data;
              2'd1: fill_buf_d[15:8]  = _mem_data;
              2'd2: fill_buf_d[23:16] = _mem_data;
              default: begin
                line_we = 1'b1;
                req_d   = 1'b0;
                state_d = S_RESP;
                // The response pulse is registered here so it is visible
                // during the RESP cycle; the address compare guards against
                // the fetcher having moved on while the fill was in flight.
                if (_fetch_en && (_pc[31:2] == fill_addr_q)) begin
                  inst_d  = fill_word;
                  ready_d = 1'b1;
                end
              end
            endcase
          end
        end
        S_RESP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control state, registered outputs and valid bits; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fill_addr_q <= '0;
      fill_buf_q  <= '0;
      ready_q     <= 1'b0;
      inst_q      <= '0;
      req_q       <= 1'b0;
      maddr_q     <= '0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_addr_q <= fill_addr_d;
      fill_buf_q  <= fill_buf_d;
      ready_q     <= ready_d;
      inst_q      <= inst_d;
      req_q       <= req_d;
      maddr_q     <= maddr_d;
      if (line_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && line_we) begin
      tag_mem_q[fill_idx]  <= fill_tag;
      data_mem_q[fill_idx] <= fill_word;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: table of fetches plus hand-written
// sequences for flush, pause, PC change during fill and asynchronous reset.
module tb_inst_cache;

  localparam int unsigned LINES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        clear;
  logic        fetch_en;
  logic [31:0] pc;
  logic        ready;
  logic [31:0] inst;
  logic        req;
  logic [31:0] maddr;
  logic        dv;
  logic [7:0]  mdata;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [31:0] sb_q[$];
  logic [31:0] gen = 32'h0;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [31:0] word;
    int unsigned gap;
  } vec_t;

  inst_cache #(.LINES(LINES)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .rdy_in          (rdy),
    ._clear          (clear),
    ._fetch_en       (fetch_en),
    ._pc             (pc),
    ._inst_ready_out (ready),
    ._inst_out       (inst),
    ._mem_req        (req),
    ._mem_addr       (maddr),
    ._mem_data_valid (dv),
    ._mem_data       (mdata)
  );

  always #5 clk = ~clk;

  // Backing memory: word 0 holds the known instruction, others a bijective scramble.
  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0513;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234 ^ gen;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ready pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_pulse: got inst %h with nothing expected", inst);
      end else begin
        chk("sb_inst", inst, sb_q.pop_front());
      end
    end
  end

  // Arbiter: deliver bytes first..last of w, with gap idle cycles before each.
  task automatic deliver(input logic [31:0] w, input int unsigned first,
                         input int unsigned last, input int unsigned gap,
                         input logic [31:0] addr);
    for (int unsigned k = first; k <= last; k++) begin
      for (int unsigned g = 0; g < gap; g++) begin
        step();
        chk1("gap_req", req, 1'b1);
        chk("gap_addr", maddr, addr);
      end
      dv    = 1'b1;
      mdata = w[8*k +: 8];
      step();
      dv    = 1'b0;
      mdata = 8'h00;
      if (k < 3) begin
        chk1("byte_req", req, 1'b1);
        chk1("byte_nordy", ready, 1'b0);
        chk("byte_addr", maddr, addr);
      end
    end
  endtask

  // Fetcher: hold PC until the response, as a stalled fetcher would.
  task automatic run_fetch(input logic [31:0] a, input bit exp_hit,
                           input logic [31:0] w, input int unsigned gap);
    pc       = a;
    fetch_en = 1'b1;
    sb_q.push_back(w);
    step();
    if (exp_hit) begin
      chk1("hit_rdy", ready, 1'b1);
      chk1("hit_noreq", req, 1'b0);
      fetch_en = 1'b0;
    end else begin
      chk1("miss_req", req, 1'b1);
      chk("miss_addr", maddr, {a[31:2], 2'b00});
      chk1("miss_nordy", ready, 1'b0);
      deliver(w, 0, 3, gap, {a[31:2], 2'b00});
      chk1("resp_rdy", ready, 1'b1);
      chk1("resp_noreq", req, 1'b0);
      fetch_en = 1'b0;
      step();
      chk1("pulse_width", ready, 1'b0);
    end
  endtask

  initial begin
    vec_t        vt[14];
    logic [31:0] w;

    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; fetch_en = 1'b0;
    pc = 32'h0; dv = 1'b0; mdata = 8'h00;

    vt[0]  = '{32'h0000_0000, 1'b0, 32'h0050_0513, 0};
    vt[1]  = '{32'h0000_0000, 1'b1, 32'h0050_0513, 0};
    vt[2]  = '{32'h0000_0004, 1'b0, memw(32'h4), 1};
    vt[3]  = '{32'h0000_0004, 1'b1, memw(32'h4), 0};
    vt[4]  = '{32'h0000_0040, 1'b0, memw(32'h40), 2};
    vt[5]  = '{32'h0000_0040, 1'b1, memw(32'h40), 0};
    vt[6]  = '{32'h0000_0000, 1'b0, 32'h0050_0513, 0};
    vt[7]  = '{32'h0000_003C, 1'b0, memw(32'h3C), 0};
    vt[8]  = '{32'h1000_003C, 1'b0, memw(32'h1000_003C), 3};
    vt[9]  = '{32'h0000_003C, 1'b0, memw(32'h3C), 0};
    vt[10] = '{32'hFFFF_FFFC, 1'b0, memw(32'hFFFF_FFFC), 1};
    vt[11] = '{32'hFFFF_FFFC, 1'b1, memw(32'hFFFF_FFFC), 0};
    vt[12] = '{32'hFFFF_FFFE, 1'b1, memw(32'hFFFF_FFFC), 0};
    vt[13] = '{32'h0000_0004, 1'b1, memw(32'h4), 0};

    // Reset state
    #12;
    chk1("rst_rdy", ready, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk1("rst_req", req, 1'b0);
    chk("rst_addr", maddr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int unsigned i = 0; i < 14; i++) begin
      run_fetch(vt[i].pc, vt[i].hit, vt[i].word, vt[i].gap);
    end

    // Back-to-back hits, with stray byte strobes that must be ignored
    dv = 1'b1; mdata = 8'hAA;
    pc = 32'h0; fetch_en = 1'b1; sb_q.push_back(32'h0050_0513);
    step();
    chk1("b2b_rdy0", ready, 1'b1);
    pc = 32'h4; sb_q.push_back(memw(32'h4));
    step();
    chk1("b2b_rdy1", ready, 1'b1);
    chk1("b2b_noreq", req, 1'b0);
    fetch_en = 1'b0; dv = 1'b0; mdata = 8'h00;
    step();
    chk1("b2b_end", ready, 1'b0);

    // Clear after two bytes: no pulse, line not written
    pc = 32'h8; fetch_en = 1'b1;
    step();
    chk1("clr_req_on", req, 1'b1);
    w = memw(32'h8);
    deliver(w, 0, 1, 1, 32'h8);
    clear = 1'b1;
    step();
    chk1("clr_req", req, 1'b0);
    chk1("clr_rdy", ready, 1'b0);
    clear = 1'b0; fetch_en = 1'b0;
    step();
    chk1("clr_rdy2", ready, 1'b0);
    chk1("clr_req2", req, 1'b0);
    gen = 32'h0F0F_0F0F;
    run_fetch(32'h8, 1'b0, memw(32'h8), 0);

    // Clear together with the 4th byte: clear wins
    pc = 32'hC; fetch_en = 1'b1;
    step();
    w = memw(32'hC);
    deliver(w, 0, 2, 0, 32'hC);
    dv = 1'b1; mdata = w[31:24]; clear = 1'b1;
    step();
    dv = 1'b0; clear = 1'b0; fetch_en = 1'b0;
    chk1("clr4_req", req, 1'b0);
    chk1("clr4_rdy", ready, 1'b0);
    step();
    chk1("clr4_rdy2", ready, 1'b0);
    run_fetch(32'hC, 1'b0, memw(32'hC), 0);

    // Pause mid-fill with byte strobes toggling
    pc = 32'h10; fetch_en = 1'b1;
    w = memw(32'h10);
    sb_q.push_back(w);
    step();
    deliver(w, 0, 1, 0, 32'h10);
    rdy = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      dv = (i % 2 == 0); mdata = 8'hEE;
      step();
      chk1("pause_req", req, 1'b1);
      chk1("pause_rdy", ready, 1'b0);
      chk("pause_addr", maddr, 32'h10);
    end
    dv = 1'b0; mdata = 8'h00; rdy = 1'b1;
    deliver(w, 2, 3, 0, 32'h10);
    chk1("pause_resp", ready, 1'b1);
    fetch_en = 1'b0;
    step();
    chk1("pause_end", ready, 1'b0);

    // PC moves during fill: line still written, no wrong-address pulse
    pc = 32'h14; fetch_en = 1'b1;
    step();
    chk("pcchg_addr", maddr, 32'h14);
    pc = 32'h18;
    w = memw(32'h14);
    deliver(w, 0, 3, 0, 32'h14);
    chk1("pcchg_nordy", ready, 1'b0);
    chk1("pcchg_noreq", req, 1'b0);
    fetch_en = 1'b0;
    step();
    run_fetch(32'h14, 1'b1, w, 0);
    run_fetch(32'h18, 1'b0, memw(32'h18), 0);

    // Asynchronous reset clears a live pulse immediately
    pc = 32'h0; fetch_en = 1'b1;
    step();
    chk1("prerst_rdy", ready, 1'b1);
    fetch_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk1("arst_rdy", ready, 1'b0);
    chk("arst_inst", inst, 32'h0);
    step();
    rst_n = 1'b1;

    // Asynchronous reset mid-fill drops the request immediately
    pc = 32'h20; fetch_en = 1'b1;
    step();
    chk1("arst_fill_req_on", req, 1'b1);
    deliver(memw(32'h20), 0, 0, 0, 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_fill_req", req, 1'b0);
    chk("arst_fill_addr", maddr, 32'h0);
    fetch_en = 1'b0;
    step();
    rst_n = 1'b1;
    run_fetch(32'h0, 1'b0, 32'h0050_0513, 0);
    run_fetch(32'h20, 1'b0, memw(32'h20), 1);

    step();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
